rf_read_arbiter: RTL and testbench
==================================

# rf_read_arbiter

Shares the single register-file read port (4-bit register ID into the 4-to-16 read decoder, 16-bit data back) between two requesters: requester 0 (pipeline decode stage) and requester 1 (debug/trace port). It is a one-stage pipeline with round-robin arbitration, a valid/ready request handshake and a per-requester registered response buffer with backpressure. The arbiter sits between the requesters and the register file, and is the only driver of the read-port register ID.

## Interface
- No parameters. Widths are fixed: 16 registers, 4-bit ID, 16-bit data.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a read pending.
- `req0_regid` in 4: register ID for requester 0.
- `req0_ready` out 1: requester 0 granted this cycle; the request is consumed.
- `rsp0_valid` out 1: response buffer 0 holds data.
- `rsp0_data` out 16: read data for requester 0.
- `rsp0_ready` in 1: requester 0 accepts the response.
- `req1_valid`, `req1_regid`, `req1_ready`, `rsp1_valid`, `rsp1_data`, `rsp1_ready`: same as above, for requester 1.
- `rf_regid` out 4: register ID driven to the register-file read port.
- `rf_data` in 16: combinational read data for `rf_regid`, valid in the same cycle.
- `conflict_cnt` out 8: saturating count of cycles in which both requesters were eligible.

## Operation
- **Eligibility.** Requester N is eligible when `reqN_valid` is 1 and slot N is free.
  - Slot N is free when `rspN_valid` is 0, or when `rspN_valid` and `rspN_ready` are both 1 in that cycle (same-cycle drain and refill).
- **Arbitration.** At most one grant per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester selected by the 1-bit priority pointer `prio` is granted.
  - After any grant, `prio` points to the other requester. With no grant, `prio` is unchanged.
- **Handshake.** `reqN_ready` is a combinational function of current inputs and state. It is 1 only in a cycle where N is granted.
  - Requesters must hold `reqN_valid` and `reqN_regid` stable until they see `ready`.
  - `reqN_ready` never depends on `reqN_ready` of the other port.
- **Read port.** In a grant cycle, `rf_regid` equals the granted requester's `regid`, combinationally. With no grant, `rf_regid` holds its last registered value.
- **Response capture.** On a grant to N:
  - `rspN_data` is loaded with `rf_data` at the rising edge.
  - `rspN_valid` is set to 1 at the same edge.
- **Response release.** When `rspN_valid` and `rspN_ready` are both 1 and N is not granted, `rspN_valid` clears at the edge.
  - `rspN_data` keeps its value while `rspN_valid` is 1 and is not accepted.
- **Conflict counter.** `conflict_cnt` increments when both requesters are eligible in a cycle. It saturates at 255.
- **Register 0.** Register 0 gets no special treatment; ID 0 reads like any other register.

## Timing
- **Latency.** A request granted in cycle t has its response visible (`rspN_valid` = 1, `rspN_data` set) in cycle t+1.
- **Throughput.**
  - One grant per cycle in aggregate.
  - Each requester can sustain one read per cycle only while it holds `rspN_ready` = 1.
  - With both requesters continuously eligible, grants alternate 0,1,0,1…
- **Reset values** (first edge with `rst_n` = 0):
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp0_data` = `rsp1_data` = 16'h0000.
  - `rf_regid` = 4'h0.
  - `prio` = 0, so requester 0 wins the first conflict.
  - `conflict_cnt` = 8'h00.
- **Ready during reset.** While `rst_n` = 0, `req0_ready` = `req1_ready` = 0, regardless of the inputs.
- **Reset mid-operation.** Pending responses are discarded without handshake. A request presented in the reset cycle is not consumed.
- **Backpressure.** If `rspN_valid` = 1 and `rspN_ready` = 0, requester N is ineligible. The other requester may still be granted in that cycle, even if it does not hold priority.

## Test plan
1. **Reset.** Hold `rst_n` = 0 for 2 cycles with both `req_valid` = 1.
   - Both `ready` = 0, both `rsp_valid` = 0, `rf_regid` = 0, `conflict_cnt` = 0.
2. **Single read.** Register file preloaded R5 = 16'hA5A5. Requester 0 only, `regid` = 5, `rsp0_ready` = 1.
   - Cycle t: `req0_ready` = 1 and `rf_regid` = 5.
   - Cycle t+1: `rsp0_valid` = 1 and `rsp0_data` = 16'hA5A5.
   - Cycle t+2: `rsp0_valid` = 0.
3. **Continuous conflict.** Both valid for 4 cycles, `regid0` = 3 (R3 = 16'h0033), `regid1` = 12 (R12 = 16'h0C0C), both `rsp_ready` = 1.
   - Grants are 0,1,0,1.
   - Each response carries the correct data one cycle after its grant.
   - `conflict_cnt` = 4.
4. **Backpressure.** Requester 0 gets a response with `rsp0_ready` = 0 for 3 cycles while `req0_valid` = 1 (`regid` = 7) and `req1_valid` = 1.
   - `req0_ready` stays 0 and `rsp0_data` is stable.
   - Requester 1 is granted every cycle.
   - When `rsp0_ready` rises, `req0` is granted in that same cycle and `rsp0_valid` stays 1 with the new data.
5. **Saturation.** Keep both requesters eligible for 300 cycles.
   - `conflict_cnt` stops at 8'hFF.
6. **Mid-flight reset.** Assert `rst_n` = 0 for one cycle while `rsp1_valid` = 1.
   - `rsp1_valid` = 0 the next cycle.
   - `prio` is back at 0: the next conflict is granted to requester 0.

Source files
------------

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one register-file read port between two requesters,
// with a registered per-requester response buffer and a saturating conflict counter.
module rf_read_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    input  logic [3:0]  req0_regid,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_data,
    input  logic        rsp0_ready,

    input  logic        req1_valid,
    input  logic [3:0]  req1_regid,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_data,
    input  logic        rsp1_ready,

    output logic [3:0]  rf_regid,
    input  logic [15:0] rf_data,

    output logic [7:0]  conflict_cnt
);

    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [15:0] rsp0_data_q, rsp0_data_d;
    logic [15:0] rsp1_data_q, rsp1_data_d;
    logic [3:0]  rf_regid_q, rf_regid_d;
    logic        prio_q, prio_d;
    logic [7:0]  conflict_cnt_q, conflict_cnt_d;

    logic elig0, elig1, gnt0, gnt1, conflict;

    always_comb begin
        // A full slot that drains this cycle can be refilled in the same cycle.
        elig0    = req0_valid && (!rsp0_valid_q || rsp0_ready);
        elig1    = req1_valid && (!rsp1_valid_q || rsp1_ready);
        conflict = elig0 && elig1;
        gnt0     = rst_n && elig0 && (!elig1 || !prio_q);
        gnt1     = rst_n && elig1 && (!elig0 || prio_q);

        rf_regid_d = rf_regid_q;
        if (gnt0) begin
            rf_regid_d = req0_regid;
        end else if (gnt1) begin
            rf_regid_d = req1_regid;
        end

        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end

        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        if (gnt0) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = rf_data;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end

        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        if (gnt1) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = rf_data;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end

        conflict_cnt_d = conflict_cnt_q;
        if (conflict && conflict_cnt_q != 8'hFF) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_data_q    <= 16'h0000;
            rsp1_data_q    <= 16'h0000;
            rf_regid_q     <= 4'h0;
            prio_q         <= 1'b0;
            conflict_cnt_q <= 8'h00;
        end else begin
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp0_data_q    <= rsp0_data_d;
            rsp1_data_q    <= rsp1_data_d;
            rf_regid_q     <= rf_regid_d;
            prio_q         <= prio_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign rf_regid     = rf_regid_d;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_data    = rsp1_data_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: inputs driven #1 after posedge, outputs checked on negedge.
module tb_rf_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]  req0_regid, req1_regid, rf_regid;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp0_data, rsp1_data, rf_data;
    logic [7:0]  conflict_cnt;
    logic [15:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rf_data = mem[rf_regid];

    rf_read_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_regid   (req0_regid),
        .req0_ready   (req0_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp0_data    (rsp0_data),
        .rsp0_ready   (rsp0_ready),
        .req1_valid   (req1_valid),
        .req1_regid   (req1_regid),
        .req1_ready   (req1_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_data    (rsp1_data),
        .rsp1_ready   (rsp1_ready),
        .rf_regid     (rf_regid),
        .rf_data      (rf_data),
        .conflict_cnt (conflict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(i) * 16'h1111;
        mem[5]  = 16'hA5A5;
        mem[3]  = 16'h0033;
        mem[12] = 16'h0C0C;

        // Reset with both requesters asserting valid
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_regid = 4'd9;
        req1_valid = 1'b1; req1_regid = 4'd10;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rf_regid", 32'(rf_regid), 32'd0);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);

        // Single read of R5 by requester 0
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_regid = 4'd5;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        check("single_req0_ready", 32'(req0_ready), 32'd1);
        check("single_rf_regid", 32'(rf_regid), 32'd5);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("single_rsp0_data", 32'(rsp0_data), 32'hA5A5);
        check("idle_rf_regid_hold", 32'(rf_regid), 32'd5);
        step();
        @(negedge clk);
        check("single_rsp0_drain", 32'(rsp0_valid), 32'd0);

        // Requester 1 alone, returning the pointer to requester 0
        req1_valid = 1'b1; req1_regid = 4'd12;
        @(negedge clk);
        check("solo1_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        check("solo1_rsp1_data", 32'(rsp1_data), 32'h0C0C);

        // Continuous conflict: grants alternate 0,1,0,1
        step();
        req0_valid = 1'b1; req0_regid = 4'd3;
        req1_valid = 1'b1; req1_regid = 4'd12;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("conf_req0_ready", 32'(req0_ready), 32'(k % 2 == 0));
            check("conf_req1_ready", 32'(req1_ready), 32'(k % 2 == 1));
            if (k > 0) begin
                if (k % 2 == 1) check("conf_rsp0_data", 32'(rsp0_data), 32'h0033);
                else            check("conf_rsp1_data", 32'(rsp1_data), 32'h0C0C);
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("conf_rsp1_valid", 32'(rsp1_valid), 32'd1);
        check("conf_rsp1_data", 32'(rsp1_data), 32'h0C0C);
        check("conf_cnt", 32'(conflict_cnt), 32'd4);

        // Backpressure: fill slot 0 with R3 and hold it
        step();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_regid = 4'd3;
        step();
        req0_regid = 4'd7;
        req1_valid = 1'b1; req1_regid = 4'd12;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_req0_ready", 32'(req0_ready), 32'd0);
            check("bp_req1_ready", 32'(req1_ready), 32'd1);
            check("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
            check("bp_rsp0_data", 32'(rsp0_data), 32'h0033);
            step();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req0_ready", 32'(req0_ready), 32'd1);
        check("bp_release_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("bp_refill_valid", 32'(rsp0_valid), 32'd1);
        check("bp_refill_data", 32'(rsp0_data), 32'h7777);
        check("bp_cnt", 32'(conflict_cnt), 32'd5);

        // Saturation: 300 conflict cycles starting from a count of 5
        step();
        req0_valid = 1'b1; req0_regid = 4'd1;
        req1_valid = 1'b1; req1_regid = 4'd2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 249) check("sat_cnt_254", 32'(conflict_cnt), 32'd254);
            if (i == 250) check("sat_cnt_255", 32'(conflict_cnt), 32'd255);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("sat_cnt_final", 32'(conflict_cnt), 32'hFF);
        step();

        // Mid-flight reset: leave rsp1 full and prio pointing at requester 1
        req1_valid = 1'b1; req1_regid = 4'd12;
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("mf_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_regid = 4'd3;
        @(negedge clk);
        check("mf_req0_ready", 32'(req0_ready), 32'd1);
        step();
        @(negedge clk);
        check("mf_rsp1_valid", 32'(rsp1_valid), 32'd1);
        rst_n = 1'b0;
        req1_valid = 1'b1;
        rsp0_ready = 1'b1;
        #1;
        check("mf_rst_req0_ready", 32'(req0_ready), 32'd0);
        check("mf_rst_req1_ready", 32'(req1_ready), 32'd0);
        step();
        rst_n = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("mf_rsp1_cleared", 32'(rsp1_valid), 32'd0);
        check("mf_rsp0_cleared", 32'(rsp0_valid), 32'd0);
        check("mf_cnt_cleared", 32'(conflict_cnt), 32'd0);
        check("mf_prio_req0_ready", 32'(req0_ready), 32'd1);
        check("mf_prio_req1_ready", 32'(req1_ready), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
